uart_cmd_parser: RTL and testbench

//  Command-processing stage downstream of the RS232 UART core. Drains the UART's
//  8-entry RX ring buffer by pointer-chasing its write address, parses ASCII

---
 rtl/uart_cmd_parser.sv | 212 +++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// ASCII register command parser between a UART RX ring buffer and its TX buffer.
// First reply byte is offered 3 cycles after a terminating CR appears; TX stalls hold state while iTxFull is high.
module uart_cmd_parser #(
  parameter int NREGS = 4,
  parameter int RXAW  = 3
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [7:0]      iRxData,
  input  logic [RXAW-1:0] iRxWrAddr,
  output logic [RXAW-1:0] oRxRdAddr,
  output logic [7:0]      oTxData,
  output logic            oTxWe,
  input  logic            iTxFull,
  output logic [7:0]      oLeds,
  output logic [7:0]      oCmdCount,
  output logic            oErr
);

  localparam int          AW       = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [7:0]  CH_CR    = 8'h0D;
  localparam logic [7:0]  CH_LF    = 8'h0A;
  localparam logic [7:0]  ADDR_LIM = 8'(48 + NREGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PARSE,
    S_DISCARD,
    S_REPLY
  } state_t;

  typedef enum logic [2:0] {
    A_SKIP,
    A_NEXT,
    A_ERR,
    A_EREPLY,
    A_READ,
    A_WRITE
  } act_t;

  state_t          r_state;
  logic [RXAW-1:0] r_rd_addr;
  logic [7:0]      r_regs [NREGS];
  logic [7:0]      r_cnt;
  logic            r_err;
  logic            r_disc;
  logic [2:0]      r_pos;
  logic            r_is_w;
  logic [AW-1:0]   r_addr;
  logic [3:0]      r_hi;
  logic [3:0]      r_lo;
  logic [7:0]      r_tx_buf [4];
  logic [2:0]      r_tx_len;
  logic [1:0]      r_tx_idx;

  logic            w_is_cr;
  logic            w_is_hex;
  logic            w_is_addr;
  logic [3:0]      w_hex_val;
  act_t            w_bad;
  act_t            w_act;
  logic [7:0]      w_rd_val;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_is_cr   = (iRxData == CH_CR);
  assign w_is_addr = (iRxData >= 8'h30) && (iRxData < ADDR_LIM);
  assign w_bad     = w_is_cr ? A_EREPLY : A_ERR;
  assign w_rd_val  = r_regs[r_addr];

  always_comb begin
    w_is_hex  = 1'b0;
    w_hex_val = 4'h0;
    if (iRxData >= 8'h30 && iRxData <= 8'h39) begin
      w_is_hex  = 1'b1;
      w_hex_val = iRxData[3:0];
    end else if ((iRxData >= 8'h41 && iRxData <= 8'h46) ||
                 (iRxData >= 8'h61 && iRxData <= 8'h66)) begin
      w_is_hex  = 1'b1;
      w_hex_val = iRxData[3:0] + 4'd9;
    end
  end

  // Grammar decision for the byte being parsed; r_pos counts accepted characters of the current line.
  always_comb begin
    w_act = A_SKIP;
    if (iRxData == CH_LF) begin
      w_act = A_SKIP;
    end else if (r_disc) begin
      w_act = w_is_cr ? A_EREPLY : A_SKIP;
    end else begin
      case (r_pos)
        3'd0: begin
          if (w_is_cr)                                  w_act = A_SKIP;
          else if (iRxData == 8'h52 || iRxData == 8'h57) w_act = A_NEXT;
          else                                           w_act = A_ERR;
        end
        3'd1:    w_act = w_is_addr ? A_NEXT : w_bad;
        3'd2: begin
          if (!r_is_w) w_act = w_is_cr ? A_READ : A_ERR;
          else         w_act = w_is_hex ? A_NEXT : w_bad;
        end
        3'd3:    w_act = w_is_hex ? A_NEXT : w_bad;
        default: w_act = w_is_cr ? A_WRITE : A_ERR;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_disc    <= 1'b0;
      r_pos     <= '0;
      r_is_w    <= 1'b0;
      r_addr    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_tx_len  <= '0;
      r_tx_idx  <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      for (int i = 0; i < 4; i++)     r_tx_buf[i] <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE, S_DISCARD: begin
          if (r_rd_addr != iRxWrAddr) r_state <= S_FETCH;
        end
        S_FETCH: r_state <= S_PARSE;
        S_PARSE: begin
          r_rd_addr <= r_rd_addr + 1'b1;
          r_tx_idx  <= '0;
          case (w_act)
            A_NEXT: begin
              r_pos   <= r_pos + 3'd1;
              r_state <= S_IDLE;
              case (r_pos)
                3'd0:    r_is_w <= (iRxData == 8'h57);
                3'd1:    r_addr <= iRxData[AW-1:0];
                3'd2:    r_hi   <= w_hex_val;
                default: r_lo   <= w_hex_val;
              endcase
            end
            A_ERR: begin
              r_disc  <= 1'b1;
              r_pos   <= '0;
              r_state <= S_DISCARD;
            end
            A_EREPLY: begin
              r_disc      <= 1'b0;
              r_pos       <= '0;
              r_err       <= 1'b1;
              r_tx_buf[0] <= 8'h45;
              r_tx_buf[1] <= CH_CR;
              r_tx_buf[2] <= CH_LF;
              r_tx_buf[3] <= 8'h00;
              r_tx_len    <= 3'd3;
              r_state     <= S_REPLY;
            end
            A_READ: begin
              r_pos       <= '0;
              r_cnt       <= r_cnt + 8'd1;
              r_tx_buf[0] <= hex_char(w_rd_val[7:4]);
              r_tx_buf[1] <= hex_char(w_rd_val[3:0]);
              r_tx_buf[2] <= CH_CR;
              r_tx_buf[3] <= CH_LF;
              r_tx_len    <= 3'd4;
              r_state     <= S_REPLY;
            end
            A_WRITE: begin
              r_pos          <= '0;
              r_cnt          <= r_cnt + 8'd1;
              r_regs[r_addr] <= {r_hi, r_lo};
              r_tx_buf[0]    <= 8'h4B;
              r_tx_buf[1]    <= CH_CR;
              r_tx_buf[2]    <= CH_LF;
              r_tx_buf[3]    <= 8'h00;
              r_tx_len       <= 3'd3;
              r_state        <= S_REPLY;
            end
            default: r_state <= r_disc ? S_DISCARD : S_IDLE;
          endcase
        end
        S_REPLY: begin
          if (!iTxFull) begin
            if ({1'b0, r_tx_idx} == r_tx_len - 3'd1) begin
              r_tx_idx <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The strobe is qualified combinationally so it can never coincide with a full TX buffer.
  assign oTxWe     = (r_state == S_REPLY) && !iTxFull;
  assign oTxData   = r_tx_buf[r_tx_idx];
  assign oRxRdAddr = r_rd_addr;
  assign oLeds     = r_regs[0];
  assign oCmdCount = r_cnt;
  assign oErr      = r_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised bench for uart_cmd_parser: line-level reference model plus directed literal checks.
module tb_uart_cmd_parser;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic [7:0] iRxData;
  logic [2:0] iRxWrAddr = 3'd0;
  logic [2:0] oRxRdAddr;
  logic [7:0] oTxData;
  logic       oTxWe;
  logic       iTxFull = 1'b0;
  logic [7:0] oLeds;
  logic [7:0] oCmdCount;
  logic       oErr;

  uart_cmd_parser #(.NREGS(4), .RXAW(3)) dut (
    .iClk(iClk), .iRst(iRst), .iRxData(iRxData), .iRxWrAddr(iRxWrAddr),
    .oRxRdAddr(oRxRdAddr), .oTxData(oTxData), .oTxWe(oTxWe), .iTxFull(iTxFull),
    .oLeds(oLeds), .oCmdCount(oCmdCount), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  // UART RX ring: synchronous read, data valid one cycle after the address changes.
  logic [7:0] rx_mem [8];
  logic [7:0] rx_q;
  always @(posedge iClk) rx_q <= rx_mem[oRxRdAddr];
  assign iRxData = rx_q;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: evaluates each CR-terminated line as a whole.
  logic [7:0]   m_reg [4];
  int           m_cnt;
  int           m_errs;
  byte unsigned m_line[$];
  byte unsigned exp_q[$];
  int           wr_ptr;

  function automatic int hexv(input byte unsigned c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic byte unsigned hexc(input int n);
    return (n < 10) ? byte'(48 + n) : byte'(55 + n);
  endfunction

  function automatic bit is_addr(input byte unsigned c);
    return (c >= "0") && (c < 8'h34);
  endfunction

  task automatic model_byte(input byte unsigned b);
    int  a;
    bit  ok;
    if (b == 8'h0A) return;
    if (b != 8'h0D) begin
      m_line.push_back(b);
      return;
    end
    if (m_line.size() == 0) return;
    ok = 0;
    if (m_line.size() == 2 && m_line[0] == "R" && is_addr(m_line[1])) begin
      a = int'(m_line[1]) - 48;
      exp_q.push_back(hexc(int'(m_reg[a][7:4])));
      exp_q.push_back(hexc(int'(m_reg[a][3:0])));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_cnt++;
      ok = 1;
    end else if (m_line.size() == 5 && m_line[0] == "W" && is_addr(m_line[1]) &&
                 hexv(m_line[2]) >= 0 && hexv(m_line[3]) >= 0 && m_line[4] != 8'h0D) begin
      ok = 0;
    end else if (m_line.size() == 4 && m_line[0] == "W" && is_addr(m_line[1]) &&
                 hexv(m_line[2]) >= 0 && hexv(m_line[3]) >= 0) begin
      a = int'(m_line[1]) - 48;
      m_reg[a] = 8'(hexv(m_line[2]) * 16 + hexv(m_line[3]));
      exp_q.push_back("K");
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_cnt++;
      ok = 1;
    end
    if (!ok) begin
      exp_q.push_back("E");
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_errs++;
    end
    m_line.delete();
  endtask

  // Output monitor: every TX strobe is checked against the model's reply stream.
  int           tx_total = 0;
  int           err_seen = 0;
  logic         wrap_seen = 1'b0;
  logic [2:0]   prev_rd;
  byte unsigned got_q[$];

  always @(negedge iClk) begin
    if (oTxWe) tx_total++;
    if (iRst) begin
      if (oTxWe) begin
        check("we_while_full", {63'd0, iTxFull}, 64'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_tx: got 0x%0h expected no strobe", oTxData);
        end else begin
          check("tx_byte", {56'd0, oTxData}, {56'd0, exp_q.pop_front()});
        end
        got_q.push_back(oTxData);
      end
      if (oErr) err_seen++;
      if (prev_rd == 3'd7 && oRxRdAddr == 3'd0) wrap_seen = 1'b1;
    end
    prev_rd = oRxRdAddr;
  end

  // iTxFull driver: 0 = empty, 1 = held full, 2 = random.
  int full_mode = 0;
  initial forever begin
    @(posedge iClk);
    #1;
    case (full_mode)
      0:       iTxFull = 1'b0;
      1:       iTxFull = 1'b1;
      default: iTxFull = ($urandom_range(0, 2) == 0);
    endcase
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic feed(input byte unsigned b);
    int guard = 0;
    while (((wr_ptr + 1) % 8) == int'(oRxRdAddr) && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) begin
      n_chk++;
      n_err++;
      $display("FAIL feed_timeout: got rd=%0d expected progress past wr=%0d", oRxRdAddr, wr_ptr);
    end
    rx_mem[wr_ptr] = b;
    wr_ptr = (wr_ptr + 1) % 8;
    iRxWrAddr = 3'(wr_ptr);
    model_byte(b);
    tick();
  endtask

  task automatic feed_str(input string s);
    for (int i = 0; i < s.len(); i++) feed(s[i]);
  endtask

  task automatic drain();
    int guard = 0;
    while ((int'(oRxRdAddr) != wr_ptr || exp_q.size() != 0) && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending bytes expected 0", exp_q.size());
    end
    repeat (6) tick();
  endtask

  task automatic check_state();
    check("leds", {56'd0, oLeds}, {56'd0, m_reg[0]});
    check("cmd_count", {56'd0, oCmdCount}, 64'(m_cnt % 256));
    check("err_pulses", 64'(err_seen), 64'(m_errs));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_cnt = 0;
    m_errs = 0;
    err_seen = 0;
    exp_q.delete();
    m_line.delete();
    got_q.delete();
    wr_ptr = 0;
    iRxWrAddr = 3'd0;
  endtask

  function automatic logic [63:0] pack_got();
    logic [63:0] v = 64'd0;
    foreach (got_q[i]) v = (v << 8) | {56'd0, got_q[i]};
    return v;
  endfunction

  function automatic byte unsigned rand_hex();
    int v = int'($urandom_range(0, 16));
    if (v == 16) return "G";
    if (v < 10) return byte'(48 + v);
    return ($urandom_range(0, 1) == 1) ? byte'(55 + v) : byte'(87 + v);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc;
    int           snap;
    int           k;
    byte unsigned b;
    for (int i = 0; i < 8; i++) rx_mem[i] = 8'h00;
    clear_model();
    iRst = 1'b0;
    repeat (3) tick();
    check("rst_rdaddr", {61'd0, oRxRdAddr}, 64'd0);
    check("rst_txdata", {56'd0, oTxData}, 64'd0);
    check("rst_txwe", {63'd0, oTxWe}, 64'd0);
    check("rst_err", {63'd0, oErr}, 64'd0);
    check("rst_cmdcount", {56'd0, oCmdCount}, 64'd0);
    check("rst_leds", {56'd0, oLeds}, 64'd0);
    iRst = 1'b1;
    tick();

    got_q.delete();
    feed_str("W0A5\r");
    drain();
    check("t1_leds", {56'd0, oLeds}, 64'hA5);
    check("t1_reply", pack_got(), 64'h4B0D0A);
    check("t1_count", {56'd0, oCmdCount}, 64'd1);

    got_q.delete();
    feed_str("R0\r");
    drain();
    check("t2_read0", pack_got(), 64'h41350D0A);
    check("t2_count", {56'd0, oCmdCount}, 64'd2);
    feed_str("W1ff\r");
    drain();
    got_q.delete();
    feed_str("R1\r");
    drain();
    check("t2_read1", pack_got(), 64'h46460D0A);

    got_q.delete();
    feed_str("X12\r");
    drain();
    check("t3_bad_cmd", pack_got(), 64'h450D0A);
    check("t3_err1", 64'(err_seen), 64'd1);
    got_q.delete();
    feed_str("W4");
    feed_str("00\r");
    drain();
    check("t3_bad_addr", pack_got(), 64'h450D0A);
    check("t3_err2", 64'(err_seen), 64'd2);
    check("t3_count", {56'd0, oCmdCount}, 64'd4);
    check_state();

    full_mode = 1;
    repeat (2) tick();
    got_q.delete();
    snap = tx_total;
    feed_str("R0\r");
    repeat (20) tick();
    check("t4_held", 64'(tx_total - snap), 64'd0);
    full_mode = 0;
    drain();
    check("t4_reply", pack_got(), 64'h41350D0A);
    check("t4_count", 64'(tx_total - snap), 64'd4);

    feed_str("R0");
    drain();
    snap = tx_total;
    feed(8'h0D);
    cyc = 1;
    while (tx_total == snap && cyc < 20) begin
      tick();
      cyc++;
    end
    check("latency_le4", {63'd0, cyc <= 4}, 64'd1);
    drain();
    check_state();

    iRst = 1'b0;
    clear_model();
    repeat (2) tick();
    iRst = 1'b1;
    feed_str("\n\n\n\n\n\n");
    drain();
    check("t5_start_rd", {61'd0, oRxRdAddr}, 64'd6);
    wrap_seen = 1'b0;
    got_q.delete();
    feed_str("W23C\r\nW23C\r\n");
    drain();
    check("t5_wrap", {63'd0, wrap_seen}, 64'd1);
    check("t5_replies", pack_got(), 64'h4B0D0A4B0D0A);
    got_q.delete();
    feed_str("R2\r");
    drain();
    check("t5_reg2", pack_got(), 64'h33430D0A);

    full_mode = 2;
    for (int c = 0; c < 160; c++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 3) begin
        feed("R");
        feed(byte'(48 + $urandom_range(0, 4)));
        if ($urandom_range(0, 5) == 0) feed(8'h0A);
        feed(8'h0D);
      end else if (k <= 7) begin
        feed("W");
        feed(byte'(48 + $urandom_range(0, 4)));
        feed(rand_hex());
        if ($urandom_range(0, 9) != 0) feed(rand_hex());
        if ($urandom_range(0, 9) == 0) feed(rand_hex());
        feed(8'h0D);
      end else if (k == 8) begin
        repeat ($urandom_range(1, 3)) begin
          b = byte'($urandom_range(0, 255));
          if (b == 8'h0D) b = 8'h21;
          feed(b);
        end
        feed(8'h0D);
      end else begin
        feed(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
      end
      if ($urandom_range(0, 3) == 0) feed(8'h0A);
      if (c % 10 == 9) begin
        drain();
        check_state();
      end
    end
    for (int a = 0; a < 4; a++) begin
      feed("R");
      feed(byte'(48 + a));
      feed(8'h0D);
    end
    drain();
    check_state();

    full_mode = 0;
    repeat (2) tick();
    feed_str("W05A\r");
    drain();
    got_q.delete();
    snap = tx_total;
    feed_str("R0\r");
    cyc = 0;
    while (tx_total - snap < 2 && cyc < 50) begin
      @(negedge iClk);
      #1;
      cyc++;
    end
    check("t6_two_bytes", 64'(tx_total - snap), 64'd2);
    iRst = 1'b0;
    snap = tx_total;
    tick();
    clear_model();
    check("t6_txwe", {63'd0, oTxWe}, 64'd0);
    check("t6_txdata", {56'd0, oTxData}, 64'd0);
    check("t6_leds", {56'd0, oLeds}, 64'd0);
    check("t6_count", {56'd0, oCmdCount}, 64'd0);
    check("t6_rdaddr", {61'd0, oRxRdAddr}, 64'd0);
    check("t6_err", {63'd0, oErr}, 64'd0);
    repeat (2) tick();
    iRst = 1'b1;
    repeat (10) tick();
    check("t6_no_more_tx", 64'(tx_total), 64'(snap));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
